bit_reverse_buffer: RTL
=======================

BIT_REVERSE_BUFFER -- requirements
Module: bit_reverse_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of bits per message (legal 2..64).
REQ-002 SHALL have parameter ADDR_W, default 4, read address width; SHALL satisfy ADDR_W >= clog2(WIDTH+2).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 new_rx_data  input  1  one-cycle strobe qualifying rx_data.
REQ-006 rx_data  input  8  received ASCII character.
REQ-007 reverse  input  1  output order mode: 1 = last-received bit first, 0 = received order.
REQ-008 clear  input  1  synchronous flush of capture state.
REQ-009 msg_ack  input  1  one-cycle strobe: printer finished with display buffer.
REQ-010 addr  input  ADDR_W  character index requested by printer.
REQ-011 data  output  8  registered ASCII character for addr.
REQ-012 msg_ready  output  1  display buffer holds an unacknowledged message.
REQ-013 msg_len  output  ADDR_W  number of printable characters per message (constant).
REQ-014 bit_count  output  clog2(WIDTH+1)  bits held in capture buffer.
REQ-015 overrun  output  1  sticky: a valid bit was dropped.

Function
- REQ-016 On new_rx_data with rx_data = "1" or "0", SHALL store bit 1/0 at capture index bit_count and increment bit_count; any other character SHALL be ignored without side effects.
- REQ-017 When bit_count reaches WIDTH and msg_ready=0, SHALL on the next edge copy capture buffer and current reverse value to the display buffer, set msg_ready=1, and return bit_count to 0.
- REQ-018 When bit_count=WIDTH and msg_ready=1 (HOLD), valid bits SHALL be dropped and overrun set; the swap SHALL occur on the edge after msg_ack.
- REQ-019 msg_ack with no pending full capture SHALL clear msg_ready on the next edge; msg_ack while msg_ready=0 SHALL be ignored.
- REQ-020 msg_ack coincident with a swap condition SHALL perform the swap; msg_ready SHALL remain 1.
- REQ-021 Write states SHALL be FILL (bit_count<WIDTH), SWAP (full, display free, one cycle), HOLD (full, display busy); SWAP -> FILL, HOLD -> SWAP on msg_ack.
- REQ-022 Read: data SHALL equal the character for addr sampled one cycle earlier (latency 1).
- REQ-023 For addr i < WIDTH: latched reverse=1 SHALL return display bit WIDTH-1-i, reverse=0 SHALL return bit i, as "1"/"0".
- REQ-024 addr >= msg_len SHALL return " " (0x20).
- REQ-025 reverse changes after a swap SHALL NOT affect the current display buffer.
- REQ-026 clear SHALL zero bit_count, capture buffer, msg_ready and overrun on the next edge, overriding coincident writes, acks and swaps; display buffer and data unaffected.

Reset
- REQ-027 rst SHALL immediately force bit_count=0, capture/display buffers=0, latched mode=1, msg_ready=0, overrun=0, data=0x00, state FILL.
- REQ-028 Reset mid-message SHALL discard partial captures; first post-reset valid bit SHALL land at index 0.

Configuration
- REQ-029 Macro BIT_REVERSE_BUFFER_CRLF_EN defined: msg_len=WIDTH+2; addr WIDTH returns "\n" (0x0A), WIDTH+1 returns "\r" (0x0D).
- REQ-030 Macro undefined: msg_len=WIDTH; those addresses return " ".

Structure
- REQ-031 Shared package bitrev_pkg SHALL hold ASCII constants (ONE, ZERO, SPACE, LF, CR) and the write-state enumeration.
- REQ-032 Read-side character select and output register SHALL be sub-module bitrev_read_mux; write FSM stays in the top module.

Verification
- REQ-033 WIDTH=8, send "1","0","1","1","0","0","0","1", reverse=1 -> msg_ready=1, addr 0..7 read "10001101", addr 8/9 = 0x0A/0x0D (CRLF_EN).
- REQ-034 Same bits, reverse=0 -> addr 0..7 read "10110001"; addr 15 -> 0x20; data valid one cycle after addr.
- REQ-035 Message complete, no ack, send 8 more bits -> bit_count=8, 9th bit sets overrun; msg_ack -> swap next edge, msg_ready stays 1.
- REQ-036 Send "1","x","0"," " -> bit_count=2; non-0/1 characters ignored.
- REQ-037 bit_count=5, assert clear and new_rx_data("1") same cycle -> bit_count=0, overrun=0, display unchanged.
- REQ-038 Assert rst mid-message (bit_count=3) -> all outputs reset values immediately, next "1" stored at index 0.

Source files
------------

// File: rtl/bitrev_pkg.sv
// Shared ASCII constants, write-side state encoding and a bit-to-character
// helper for the bit reverse buffer.
package bitrev_pkg;

  localparam logic [7:0] ONE   = 8'h31;
  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_SWAP = 2'd1,
    ST_HOLD = 2'd2
  } wr_state_e;

  function automatic logic [7:0] bit_char(input logic b);
    return b ? ONE : ZERO;
  endfunction

endpackage

// File: rtl/bitrev_read_mux.sv
// Printer-side character select with a one-cycle registered output.
// With BIT_REVERSE_BUFFER_CRLF_EN defined, addresses WIDTH/WIDTH+1 return LF/CR.
module bitrev_read_mux
  import bitrev_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  disp_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [7:0]        data_o
);

  logic [WIDTH-1:0] sel_bits;
  logic [31:0]      addr_ext;
  logic [7:0]       data_d;
  logic [7:0]       data_q;

  // Latched mode 1 presents the last-received bit at address 0.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sel
      assign sel_bits[gi] = mode_i ? disp_i[WIDTH-1-gi] : disp_i[gi];
    end
  endgenerate

  assign addr_ext = 32'(addr_i);

  always_comb begin
    data_d = SPACE;
    for (int i = 0; i < WIDTH; i++) begin
      if (addr_ext == 32'(i)) data_d = bit_char(sel_bits[i]);
    end
`ifdef BIT_REVERSE_BUFFER_CRLF_EN
    if (addr_ext == 32'(WIDTH))     data_d = LF;
    if (addr_ext == 32'(WIDTH + 1)) data_d = CR;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= 8'h00;
    else     data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/bit_reverse_buffer.sv
// Captures ASCII '0'/'1' bits into a WIDTH-bit message and double-buffers it
// for a printer. Optional CR/LF trailer: define BIT_REVERSE_BUFFER_CRLF_EN.
module bit_reverse_buffer
  import bitrev_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       new_rx_data,
  input  logic [7:0]                 rx_data,
  input  logic                       reverse,
  input  logic                       clear,
  input  logic                       msg_ack,
  input  logic [ADDR_W-1:0]          addr,
  output logic [7:0]                 data,
  output logic                       msg_ready,
  output logic [ADDR_W-1:0]          msg_len,
  output logic [$clog2(WIDTH+1)-1:0] bit_count,
  output logic                       overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  wr_state_e        state_q;
  logic [CW-1:0]    bcnt_q;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] cap_d;
  logic [WIDTH-1:0] disp_q;
  logic             mode_q;
  logic             msg_ready_q;
  logic             overrun_q;
  logic             valid_bit;
  logic             ready_after_ack;

  assign valid_bit = new_rx_data && ((rx_data == ONE) || (rx_data == ZERO));
  // Only meaningful in FILL, where no full capture is pending.
  assign ready_after_ack = msg_ready_q && !msg_ack;

  always_comb begin
    cap_d = cap_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (bcnt_q == CW'(i)) cap_d[i] = (rx_data == ONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      bcnt_q      <= '0;
      cap_q       <= '0;
      disp_q      <= '0;
      mode_q      <= 1'b1;
      msg_ready_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (clear) begin
      state_q     <= ST_FILL;
      bcnt_q      <= '0;
      cap_q       <= '0;
      msg_ready_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (msg_ack && msg_ready_q) msg_ready_q <= 1'b0;
          if (valid_bit) begin
            cap_q  <= cap_d;
            bcnt_q <= bcnt_q + CW'(1);
            if (bcnt_q == CW'(WIDTH - 1))
              state_q <= ready_after_ack ? ST_HOLD : ST_SWAP;
          end
        end
        ST_HOLD: begin
          if (valid_bit) overrun_q <= 1'b1;
          if (msg_ack)   state_q   <= ST_SWAP;
        end
        ST_SWAP: begin
          // An ack arriving here is absorbed: the new message replaces the old.
          if (valid_bit) overrun_q <= 1'b1;
          disp_q      <= cap_q;
          mode_q      <= reverse;
          msg_ready_q <= 1'b1;
          bcnt_q      <= '0;
          state_q     <= ST_FILL;
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  bitrev_read_mux #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W)
  ) u_read_mux (
    .clk   (clk),
    .rst   (rst),
    .disp_i(disp_q),
    .mode_i(mode_q),
    .addr_i(addr),
    .data_o(data)
  );

`ifdef BIT_REVERSE_BUFFER_CRLF_EN
  assign msg_len = ADDR_W'(WIDTH + 2);
`else
  assign msg_len = ADDR_W'(WIDTH);
`endif

  assign msg_ready = msg_ready_q;
  assign bit_count = bcnt_q;
  assign overrun   = overrun_q;

endmodule
